// File: rtl/cpu_pkg.sv
// Shared constants and types for the pipeline hazard / forwarding control.
//   FWD_*          : 2-bit ALU operand-mux select codes
//   REG_ZERO       : architectural zero register, never forwarded
//   stage_meta_t   : EX-stage destination metadata {dest, regwrite, memread}
//   dest_meta_t    : MEM/WB destination metadata {dest, regwrite}
package cpu_pkg;
  localparam int CPU_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_IDEX = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [CPU_REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [CPU_REG_ADDR_W-1:0] dest;
    logic                      regwrite;
    logic                      memread;
  } stage_meta_t;

  // Past EX nothing needs the load flag any more.
  typedef struct packed {
    logic [CPU_REG_ADDR_W-1:0] dest;
    logic                      regwrite;
  } dest_meta_t;
endpackage

// File: rtl/fwd_select.sv
// Forward-select comparator for one ALU operand.
//   i_src          : source register of the instruction in EX
//   i_mem_dest/rw  : destination metadata of the MEM-stage instruction
//   i_wb_dest/rw   : destination metadata of the WB-stage instruction
//   o_sel          : FWD_MEM / FWD_WB / FWD_IDEX
// The younger producer (MEM) wins over WB; register zero never matches.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = CPU_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic [REG_ADDR_W-1:0] i_mem_dest,
  input  logic                  i_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] i_wb_dest,
  input  logic                  i_wb_regwrite,
  output logic [1:0]            o_sel
);
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_regwrite && (i_mem_dest != '0) && (i_mem_dest == i_src);
  assign w_wb_hit  = i_wb_regwrite  && (i_wb_dest  != '0) && (i_wb_dest  == i_src);

  always_comb begin
    o_sel = FWD_IDEX;
    if (w_mem_hit)     o_sel = FWD_MEM;
    else if (w_wb_hit) o_sel = FWD_WB;
  end
endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
// Keeps a shadow copy of destination metadata for EX/MEM/WB, derives the
// operand-forwarding selects, detects load-use hazards and counts stall cycles.
//   Clk, Reset            : clock, synchronous active-high reset
//   ID_Rs/ID_Rt/ID_Dest   : register fields of the decode instruction
//   ID_RegWrite/MemRead   : decode instruction writes a register / is a load
//   ID_UsesRt             : decode instruction reads rt
//   Flush                 : branch taken, decode instruction is squashed
//   MemBusy               : data memory not ready, whole pipe frozen
//   forwardA/forwardB     : ALU operand selects
//   Stall                 : load-use stall
//   PCWrite/IFIDWrite     : front-end update enables
//   StallCount            : saturating count of Stall|MemBusy cycles
module hazard_forward_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W  = CPU_REG_ADDR_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [REG_ADDR_W-1:0]  ID_Rs,
  input  logic [REG_ADDR_W-1:0]  ID_Rt,
  input  logic [REG_ADDR_W-1:0]  ID_Dest,
  input  logic                   ID_RegWrite,
  input  logic                   ID_MemRead,
  input  logic                   ID_UsesRt,
  input  logic                   Flush,
  input  logic                   MemBusy,
  output logic [1:0]             forwardA,
  output logic [1:0]             forwardB,
  output logic                   Stall,
  output logic                   PCWrite,
  output logic                   IFIDWrite,
  output logic [STALL_CNT_W-1:0] StallCount
);
  logic [REG_ADDR_W-1:0]  r_ex_rs;
  logic [REG_ADDR_W-1:0]  r_ex_rt;
  stage_meta_t            r_ex;
  dest_meta_t             r_mem;
  dest_meta_t             r_wb;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_stall;
  logic w_bubble;
  logic w_hold;

  // Load in EX whose result the decode instruction needs next cycle.
  assign w_stall = r_ex.memread && r_ex.regwrite && (r_ex.dest != REG_ZERO) &&
                   ((r_ex.dest == ID_Rs) || (ID_UsesRt && (r_ex.dest == ID_Rt)));

  // Stall and Flush together still produce a single bubble.
  assign w_bubble = w_stall || Flush;
  assign w_hold   = w_stall || MemBusy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ex_rs <= '0;
      r_ex_rt <= '0;
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
    end else if (!MemBusy) begin
      r_wb           <= r_mem;
      r_mem.dest     <= r_ex.dest;
      r_mem.regwrite <= r_ex.regwrite;
      if (w_bubble) begin
        r_ex_rs <= '0;
        r_ex_rt <= '0;
        r_ex    <= '0;
      end else begin
        r_ex_rs       <= ID_Rs;
        r_ex_rt       <= ID_Rt;
        r_ex.dest     <= ID_Dest;
        r_ex.regwrite <= ID_RegWrite;
        r_ex.memread  <= ID_MemRead;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      r_stall_cnt <= '0;
    else if (w_hold && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_src          (r_ex_rs),
    .i_mem_dest     (r_mem.dest),
    .i_mem_regwrite (r_mem.regwrite),
    .i_wb_dest      (r_wb.dest),
    .i_wb_regwrite  (r_wb.regwrite),
    .o_sel          (forwardA)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_src          (r_ex_rt),
    .i_mem_dest     (r_mem.dest),
    .i_mem_regwrite (r_mem.regwrite),
    .i_wb_dest      (r_wb.dest),
    .i_wb_regwrite  (r_wb.regwrite),
    .o_sel          (forwardB)
  );

  assign Stall      = w_stall;
  assign PCWrite    = ~w_hold;
  assign IFIDWrite  = ~w_hold;
  assign StallCount = r_stall_cnt;
endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
  logic        Clk;
  logic        Reset;
  logic [4:0]  ID_Rs, ID_Rt, ID_Dest;
  logic        ID_RegWrite, ID_MemRead, ID_UsesRt;
  logic        Flush, MemBusy;
  logic [1:0]  forwardA, forwardB;
  logic        Stall, PCWrite, IFIDWrite;
  logic [15:0] StallCount;

  int checks   = 0;
  int failures = 0;

  hazard_forward_unit dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Dest(ID_Dest),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_UsesRt(ID_UsesRt),
    .Flush(Flush), .MemBusy(MemBusy),
    .forwardA(forwardA), .forwardB(forwardB),
    .Stall(Stall), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .StallCount(StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: an in-flight instruction list, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    int src1;
    int src2;
    int dest;
    bit wr;
    bit ld;
  } instr_t;

  instr_t m_pipe [3];
  int     m_cnt;

  function automatic instr_t nop_instr();
    instr_t n;
    n.src1 = 0; n.src2 = 0; n.dest = 0; n.wr = 0; n.ld = 0;
    return n;
  endfunction

  // Nearest older producer of a source register decides where its value lives.
  function automatic int m_fwd(int src);
    if (src == 0) return 0;
    for (int s = 1; s <= 2; s++)
      if (m_pipe[s].wr && m_pipe[s].dest == src)
        return (s == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    instr_t e;
    e = m_pipe[0];
    if (!(e.ld && e.wr) || e.dest == 0) return 0;
    return (e.dest == int'(ID_Rs)) || (ID_UsesRt && e.dest == int'(ID_Rt));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input int rs, input int rt, input int dst,
                        input bit wr, input bit ld, input bit urt);
    ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_Dest = 5'(dst);
    ID_RegWrite = wr; ID_MemRead = ld; ID_UsesRt = urt;
  endtask

  task automatic settle();
    bit st;
    @(negedge Clk);
    st = m_stall();
    chk("forwardA", int'(forwardA), m_fwd(m_pipe[0].src1));
    chk("forwardB", int'(forwardB), m_fwd(m_pipe[0].src2));
    chk("Stall", int'(Stall), int'(st));
    chk("PCWrite", int'(PCWrite), int'(!(st || MemBusy)));
    chk("IFIDWrite", int'(IFIDWrite), int'(!(st || MemBusy)));
    chk("StallCount", int'(StallCount), m_cnt);
  endtask

  task automatic tick();
    bit st;
    instr_t n;
    @(posedge Clk);
    st = m_stall();
    if (Reset) begin
      for (int s = 0; s < 3; s++) m_pipe[s] = nop_instr();
      m_cnt = 0;
    end else begin
      if ((st || MemBusy) && m_cnt < 65535) m_cnt++;
      if (!MemBusy) begin
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        if (st || Flush) n = nop_instr();
        else begin
          n.src1 = int'(ID_Rs); n.src2 = int'(ID_Rt); n.dest = int'(ID_Dest);
          n.wr = ID_RegWrite; n.ld = ID_MemRead;
        end
        m_pipe[0] = n;
      end
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic nops(input int n);
    set_id(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int c0;
    for (int s = 0; s < 3; s++) m_pipe[s] = nop_instr();
    m_cnt = 0;
    Reset = 1'b1; Flush = 1'b0; MemBusy = 1'b0;
    set_id(0, 0, 0, 0, 0, 0);
    #1;
    tick(); tick();
    Reset = 1'b0;

    // Reset state
    settle();
    chk("rst_fwdA", int'(forwardA), 0);
    chk("rst_fwdB", int'(forwardB), 0);
    chk("rst_stall", int'(Stall), 0);
    chk("rst_pcw", int'(PCWrite), 1);
    chk("rst_cnt", int'(StallCount), 0);
    tick();

    // add $3,$1,$2 ; add $4,$3,$5
    set_id(1, 2, 3, 1, 0, 1); step();
    set_id(3, 5, 4, 1, 0, 1); step();
    set_id(0, 0, 0, 0, 0, 0); settle();
    chk("exmem_fwdA", int'(forwardA), 2);
    chk("exmem_fwdB", int'(forwardB), 0);
    chk("exmem_stall", int'(Stall), 0);
    tick();
    nops(3);

    // add $3 ; nop ; sub $6,$7,$3
    set_id(1, 2, 3, 1, 0, 1); step();
    set_id(0, 0, 0, 0, 0, 0); step();
    set_id(7, 3, 6, 1, 0, 1); step();
    set_id(0, 0, 0, 0, 0, 0); settle();
    chk("wb_fwdB", int'(forwardB), 1);
    chk("wb_fwdA", int'(forwardA), 0);
    tick();
    nops(3);

    // add $3 ; add $3 ; or $8,$3,$3 : MEM wins
    set_id(1, 2, 3, 1, 0, 1); step();
    set_id(1, 2, 3, 1, 0, 1); step();
    set_id(3, 3, 8, 1, 0, 1); step();
    set_id(0, 0, 0, 0, 0, 0); settle();
    chk("prio_fwdA", int'(forwardA), 2);
    chk("prio_fwdB", int'(forwardB), 2);
    tick();
    nops(3);

    // lw $2,0($1) ; add $4,$2,$2
    set_id(1, 2, 2, 1, 1, 0); step();
    set_id(2, 2, 4, 1, 0, 1); settle();
    chk("lu_stall", int'(Stall), 1);
    chk("lu_pcw", int'(PCWrite), 0);
    chk("lu_ifid", int'(IFIDWrite), 0);
    tick();
    settle();
    chk("lu_cnt", int'(StallCount), 1);
    chk("lu_stall_drop", int'(Stall), 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0); settle();
    chk("lu_fwdA", int'(forwardA), 1);
    chk("lu_fwdB", int'(forwardB), 1);
    tick();
    nops(3);

    // Register zero is never forwarded and never stalls
    set_id(1, 2, 0, 1, 0, 1); step();
    set_id(0, 0, 5, 1, 0, 1); step();
    set_id(0, 0, 0, 0, 0, 0); settle();
    chk("r0_fwdA", int'(forwardA), 0);
    chk("r0_fwdB", int'(forwardB), 0);
    tick();
    set_id(1, 0, 0, 1, 1, 0); step();
    set_id(0, 0, 7, 1, 0, 1); settle();
    chk("r0_lw_stall", int'(Stall), 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0); settle();
    chk("r0_lw_fwdA", int'(forwardA), 0);
    chk("r0_lw_fwdB", int'(forwardB), 0);
    tick();
    nops(3);

    // MemBusy across a load-use, then Reset (with MemBusy) during the stall
    set_id(1, 2, 2, 1, 1, 0); step();
    set_id(2, 2, 4, 1, 0, 1);
    c0 = int'(StallCount);
    MemBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("busy_stall_held", int'(Stall), 1);
      chk("busy_pcw", int'(PCWrite), 0);
      tick();
    end
    MemBusy = 1'b0;
    settle();
    chk("busy_cnt", int'(StallCount), c0 + 3);
    chk("busy_stall_after", int'(Stall), 1);
    Reset = 1'b1; MemBusy = 1'b1;
    tick();
    Reset = 1'b0; MemBusy = 1'b0;
    settle();
    chk("rst2_stall", int'(Stall), 0);
    chk("rst2_fwdA", int'(forwardA), 0);
    chk("rst2_fwdB", int'(forwardB), 0);
    chk("rst2_cnt", int'(StallCount), 0);
    tick();

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      Flush   = ($urandom_range(0, 9) == 0);
      MemBusy = ($urandom_range(0, 7) == 0);
      Reset   = ($urandom_range(0, 49) == 0);
      step();
    end
    Flush = 1'b0; MemBusy = 1'b0; Reset = 1'b0;
    nops(2);

    // Counter saturation: hold MemBusy past 2^16 cycles
    MemBusy = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    settle();
    chk("sat_cnt", int'(StallCount), 16'hFFFF);
    tick();
    settle();
    chk("sat_hold", int'(StallCount), 16'hFFFF);
    MemBusy = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
